// File: rtl/apb_uart_tx.sv
// apb_uart_tx: APB-programmable UART transmitter with a TX FIFO and a baud divisor register.
// Define APB_UART_TX_PARITY_EN to append an even-parity bit (11-bit frame instead of 10).
module apb_uart_tx #(
  parameter int          FifoDepth  = 8,
  parameter logic [15:0] DefaultDiv = 16'd15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [3:0]  paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int AW = $clog2(FifoDepth);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [7:0] mem [FifoDepth];
  logic [AW:0] wp, rp, cnt;
  logic [6:0] cnt_ext;
  logic [3:0] cnt_sat;
  logic [15:0] div, div_lat, baud;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic [1:0] reg_sel;
  logic [31:0] rdata;
  logic acc, err, full, empty, push, pop, busy, tick, unused;
`ifdef APB_UART_TX_PARITY_EN
  logic par;
`endif
  // Bus responses are forced quiet while reset is held.
  assign acc = psel_i & penable_i & rst_ni;
  assign pready_o = psel_i & penable_i;
  assign reg_sel = paddr_i[3:2];
  assign cnt = wp - rp;
  assign cnt_ext = 7'(cnt);
  assign cnt_sat = (cnt_ext > 7'd15) ? 4'hf : cnt_ext[3:0];
  assign empty = (cnt == '0);
  assign full = cnt[AW];
  assign busy = (state != IDLE);
  assign pop = !busy && !empty;
  assign tick = (baud == div_lat);
  assign irq_o = empty & ~busy;
  assign err = acc & (((reg_sel == 2'd0) & pwrite_i & full) | ((reg_sel == 2'd1) & pwrite_i) | (reg_sel == 2'd3));
  assign push = acc & pwrite_i & (reg_sel == 2'd0) & ~full;
  assign rdata = (reg_sel == 2'd1) ? {24'b0, cnt_sat, 1'b0, busy, empty, full} :
                 (reg_sel == 2'd2) ? {16'b0, div} : '0;
  assign prdata_o = (acc & ~pwrite_i & ~err) ? rdata : '0;
  assign pslverr_o = err;
  assign unused = ^{pwdata_i[31:16], paddr_i[1:0]};
  always_ff @(posedge clk_i) begin
    if (push) mem[wp[AW-1:0]] <= pwdata_i[7:0];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
      div <= DefaultDiv;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (acc && pwrite_i && reg_sel == 2'd2) div <= pwdata_i[15:0];
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      tx_o <= 1'b1;
      shreg <= '0;
      div_lat <= '0;
      baud <= '0;
      bit_idx <= '0;
`ifdef APB_UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      baud <= (state == IDLE || tick) ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (pop) begin
          state <= START;
          tx_o <= 1'b0;
          shreg <= mem[rp[AW-1:0]];
          div_lat <= div;
`ifdef APB_UART_TX_PARITY_EN
          par <= ^mem[rp[AW-1:0]];
`endif
        end
        START: if (tick) begin
          state <= DATA;
          tx_o <= shreg[0];
          bit_idx <= '0;
        end
        DATA: if (tick) begin
          if (bit_idx == 3'd7) begin
`ifdef APB_UART_TX_PARITY_EN
            state <= PARITY;
            tx_o <= par;
`else
            state <= STOP;
            tx_o <= 1'b1;
`endif
          end else begin
            tx_o <= shreg[1];
            shreg <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end
`ifdef APB_UART_TX_PARITY_EN
        PARITY: if (tick) begin
          state <= STOP;
          tx_o <= 1'b1;
        end
`endif
        STOP: if (tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_uart_tx.sv
// tb_apb_uart_tx: randomized bench; expected serial frames come from a cycle-sampling UART receiver model.
module tb_apb_uart_tx;
  logic clk = 1'b0, rst_ni = 1'b0, psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0] paddr = '0;
  logic [31:0] pwdata = '0, prdata;
  logic pready, pslverr, tx, irq;
  int checks = 0, errors = 0, cyc = 0;
`ifdef APB_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  apb_uart_tx dut (.clk_i(clk), .rst_ni(rst_ni), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
                   .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
                   .pslverr_o(pslverr), .tx_o(tx), .irq_o(irq));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500us;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  // Line order: start(0), 8 data bits LSB first, even parity when enabled, stop(1).
  function automatic logic [NB-1:0] exp_frame(input logic [7:0] b);
`ifdef APB_UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction
  task automatic apb(input bit wr, input logic [3:0] a, input logic [31:0] d, output logic [31:0] rd, output logic er);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rd = prdata; er = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask
  // Waits for a start bit, then samples every cycle of every bit period p; tok drops if a bit is not stable.
  task automatic receive(input int p, output logic [NB-1:0] fr, output bit tok, output int gap, output bit got);
    got = 0; gap = 0; tok = 1; fr = '0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clk);
      if (tx === 1'b0) got = 1; else gap++;
    end
    if (!got) return;
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < p; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (c == 0) fr[b] = tx; else if (tx !== fr[b]) tok = 0;
      end
  endtask
  task automatic test_reset;
    logic [31:0] rd; logic er;
    psel = 1'b1; penable = 1'b1; paddr = 4'hC; pwrite = 1'b0;
    #12;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL reset_irq got %b want 1", irq); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %b want 0", pslverr); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h want 0", prdata); end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    apb(1'b0, 4'h4, 32'h0, rd, er);
    checks++; if (rd !== 32'h2 || er !== 1'b0) begin errors++; $display("FAIL reset_status got %h/%b want 00000002/0", rd, er); end
    apb(1'b0, 4'h8, 32'h0, rd, er);
    checks++; if (rd !== 32'd15) begin errors++; $display("FAIL reset_div got %0d want 15", rd); end
    apb(1'b0, 4'h0, 32'h0, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL txdata_read got %h/%b want 0/0", rd, er); end
    @(negedge clk); psel = 1'b1; penable = 1'b0; paddr = 4'h8; pwrite = 1'b0;
    #1;
    checks++; if (prdata !== 32'h0 || pready !== 1'b0) begin errors++; $display("FAIL setup_phase got %h/%b want 0/0", prdata, pready); end
    @(negedge clk); penable = 1'b1;
    #1;
    checks++; if (pready !== 1'b1) begin errors++; $display("FAIL access_pready got %b want 1", pready); end
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
  endtask
  task automatic test_default_frame;
    logic [31:0] rd; logic er; logic [NB-1:0] fr; bit tok, got; int gap;
    apb(1'b1, 4'h0, 32'h55, rd, er);
    receive(16, fr, tok, gap, got);
    checks++; if (!got) begin errors++; $display("FAIL default_start no start bit seen"); end
    checks++; if (fr !== exp_frame(8'h55)) begin errors++; $display("FAIL default_frame got %b want %b", fr, exp_frame(8'h55)); end
    checks++; if (!tok) begin errors++; $display("FAIL default_timing bit not 16 stable cycles got 0 want 1"); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL default_irq got %b want 1", irq); end
  endtask
  task automatic test_errors;
    logic [31:0] rd; logic er;
    apb(1'b0, 4'hC, 32'h0, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_read_c got %h/%b want 0/1", rd, er); end
    apb(1'b1, 4'h4, 32'hFF, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_write_status got %b want 1", er); end
    apb(1'b1, 4'hC, 32'h3, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_write_c got %b want 1", er); end
    apb(1'b0, 4'h4, 32'h0, rd, er);
    checks++; if (rd !== 32'h2 || er !== 1'b0) begin errors++; $display("FAIL err_status got %h/%b want 00000002/0", rd, er); end
    apb(1'b0, 4'h8, 32'h0, rd, er);
    checks++; if (rd !== 32'd15) begin errors++; $display("FAIL err_div got %0d want 15", rd); end
  endtask
  task automatic test_div0;
    logic [31:0] rd; logic er; logic [NB-1:0] fr; bit tok, got; int gap;
    apb(1'b1, 4'h8, 32'h0, rd, er);
    apb(1'b0, 4'h8, 32'h0, rd, er);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL div0_read got %0d want 0", rd); end
    apb(1'b1, 4'h0, 32'hA5, rd, er);
    receive(1, fr, tok, gap, got);
    checks++; if (!got || fr !== exp_frame(8'hA5)) begin errors++; $display("FAIL div0_frame got %b want %b", fr, exp_frame(8'hA5)); end
    checks++; if (!tok) begin errors++; $display("FAIL div0_timing got 0 want 1"); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL div0_irq got %b want 1", irq); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] rd; logic er; logic [7:0] q[$];
    int n;
    apb(1'b1, 4'h8, 32'($urandom_range(0, 3)), rd, er);
    apb(1'b0, 4'h8, 32'h0, rd, er);
    n = $urandom_range(3, 5);
    fork
      begin
        logic [31:0] r2; logic e2; logic [7:0] b;
        for (int i = 0; i < n; i++) begin
          b = 8'($urandom);
          apb(1'b1, 4'h0, {24'h0, b}, r2, e2);
          q.push_back(b);
        end
      end
      begin
        logic [NB-1:0] fr; bit tok, got; int gap; logic [7:0] e;
        for (int i = 0; i < n; i++) begin
          receive(int'(rd) + 1, fr, tok, gap, got);
          e = (q.size() != 0) ? q.pop_front() : 8'h0;
          checks++; if (!got || fr !== exp_frame(e)) begin errors++; $display("FAIL b2b_frame%0d got %b want %b", i, fr, exp_frame(e)); end
          checks++; if (!tok) begin errors++; $display("FAIL b2b_timing%0d got 0 want 1", i); end
          if (i > 0) begin
            checks++; if (gap != 1) begin errors++; $display("FAIL b2b_gap%0d got %0d want 1", i, gap); end
          end
        end
      end
    join
  endtask
  task automatic test_random;
    logic [31:0] rd; logic er; logic [7:0] q[$];
    int n, d;
    for (int r = 0; r < 6; r++) begin
      d = $urandom_range(0, 3);
      apb(1'b1, 4'h8, 32'(d), rd, er);
      n = $urandom_range(1, 4);
      fork
        begin
          logic [31:0] r2; logic e2; logic [7:0] b;
          for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 15)) @(negedge clk);
            b = 8'($urandom);
            apb(1'b1, 4'h0, {24'h0, b}, r2, e2);
            checks++; if (e2 !== 1'b0) begin errors++; $display("FAIL rand_push_err got %b want 0", e2); end
            q.push_back(b);
          end
        end
        begin
          logic [NB-1:0] fr; bit tok, got; int gap; logic [7:0] e;
          for (int i = 0; i < n; i++) begin
            receive(d + 1, fr, tok, gap, got);
            e = (q.size() != 0) ? q.pop_front() : 8'h0;
            checks++; if (!got || fr !== exp_frame(e)) begin errors++; $display("FAIL rand_frame r%0d i%0d got %b want %b", r, i, fr, exp_frame(e)); end
            checks++; if (!tok) begin errors++; $display("FAIL rand_timing r%0d i%0d got 0 want 1", r, i); end
          end
        end
      join
    end
  endtask
  task automatic test_div_change;
    logic [31:0] rd; logic er;
    apb(1'b1, 4'h8, 32'd2, rd, er);
    fork
      begin
        logic [31:0] r2; logic e2;
        apb(1'b1, 4'h0, 32'h3C, r2, e2);
        apb(1'b1, 4'h0, 32'hC3, r2, e2);
        apb(1'b1, 4'h8, 32'd5, r2, e2);
      end
      begin
        logic [NB-1:0] fr; bit tok, got; int gap;
        receive(3, fr, tok, gap, got);
        checks++; if (!got || fr !== exp_frame(8'h3C) || !tok) begin errors++; $display("FAIL divchg_old got %b/%b want %b/1", fr, tok, exp_frame(8'h3C)); end
        receive(6, fr, tok, gap, got);
        checks++; if (!got || fr !== exp_frame(8'hC3) || !tok) begin errors++; $display("FAIL divchg_new got %b/%b want %b/1", fr, tok, exp_frame(8'hC3)); end
      end
    join
  endtask
  task automatic test_full;
    logic [31:0] rd; logic er;
    apb(1'b1, 4'h8, 32'd100, rd, er);
    for (int i = 0; i < 10; i++) begin
      apb(1'b1, 4'h0, $urandom, rd, er);
      checks++; if (er !== (i == 9)) begin errors++; $display("FAIL full_push%0d pslverr got %b want %b", i, er, (i == 9)); end
    end
    apb(1'b0, 4'h4, 32'h0, rd, er);
    checks++; if (rd !== 32'h85) begin errors++; $display("FAIL full_status got %h want 00000085", rd); end
    @(negedge clk); rst_ni = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    apb(1'b0, 4'h4, 32'h0, rd, er);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL full_flush got %h want 00000002", rd); end
  endtask
  task automatic test_reset_mid_frame;
    logic [31:0] rd; logic er; bit got, stuck;
    int c0;
    got = 0; stuck = 0;
    apb(1'b1, 4'h0, 32'hF0, rd, er);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (tx === 1'b0);
    end
    checks++; if (!got) begin errors++; $display("FAIL midrst_start no start bit seen"); end
    c0 = cyc;
    apb(1'b1, 4'h0, 32'h11, rd, er);
    while (cyc < c0 + 72) @(negedge clk);
    checks++; if (tx !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL midrst_bit3 tx/irq got %b/%b want 0/0", tx, irq); end
    rst_ni = 1'b0;
    #1;
    checks++; if (tx !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL midrst_abort tx/irq got %b/%b want 1/1", tx, irq); end
    @(negedge clk); rst_ni = 1'b1;
    apb(1'b0, 4'h4, 32'h0, rd, er);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL midrst_status got %h want 00000002", rd); end
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) stuck = 1;
    end
    checks++; if (stuck) begin errors++; $display("FAIL midrst_discard line left idle got 0 want 1"); end
  endtask
  initial begin
    test_reset;
    test_default_frame;
    test_errors;
    test_div0;
    test_back_to_back;
    test_random;
    test_div_change;
    test_full;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
